// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes, fetch FSM
// states and the default reset vector.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JR     = 2'd3
  } sel_pc_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch immediate is a signed word offset; turn it into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the fetch stage. Only the low 26 bits
// of the instruction word are ever needed (jump index / branch immediate).
module fetch_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] inst,
  input  logic [1:0]  sel_pc,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc  = pc_plus4;
    misalign = 1'b0;
    case (sel_pc_e'(sel_pc))
      PC_SEQ:    next_pc = pc_plus4;
      PC_JUMP:   next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
      PC_BRANCH: next_pc = pc_plus4 + branch_offset(inst[15:0]);
      PC_JR: begin
        // Low bits are dropped so fetch stays aligned; the error is flagged.
        next_pc  = {jr_addr[31:2], 2'b00};
        misalign = |jr_addr[1:0];
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle requests to
// instruction memory and holds the fetched word until the datapath consumes it.
//
// state  | meaning
// S_REQ  | imem_req high for one cycle; zero-latency data accepted here
// S_WAIT | request outstanding, waiting for imem_rvalid
// S_HOLD | inst/pc valid; waiting for inst_ready to advance the PC
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        inst_ready,
  input  logic [1:0]  sel_pc,
  input  logic [31:0] jr_addr,
  output logic        err_misalign
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;
  logic        err_q;
  logic        capture;
  logic        advance;
  logic [31:0] next_pc;
  logic        misalign;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   state_d = imem_rvalid ? S_HOLD : S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_HOLD;
      S_HOLD:  if (inst_ready) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  // The request is masked while reset is held, since S_REQ is also the reset state.
  always_comb begin
    imem_req = 1'b0;
    capture  = 1'b0;
    advance  = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req = nrst;
        capture  = imem_rvalid;
      end
      S_WAIT:  capture = imem_rvalid;
      S_HOLD:  advance = inst_ready;
      default: ;
    endcase
  end

  fetch_next_pc u_next_pc (
    .pc      (pc_q),
    .inst    (inst_q[25:0]),
    .sel_pc  (sel_pc),
    .jr_addr (jr_addr),
    .next_pc (next_pc),
    .misalign(misalign)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_q    <= RESET_PC_ALIGNED;
      inst_q  <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (capture) begin
        inst_q  <= imem_rdata;
        valid_q <= 1'b1;
      end
      if (advance) begin
        pc_q    <= next_pc;
        valid_q <= 1'b0;
        if (misalign) err_q <= 1'b1;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign inst         = inst_q;
  assign inst_valid   = valid_q;
  assign err_misalign = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model, an
// architectural next-PC model checked every cycle, and literal spot checks.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        nrst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_ready;
  logic [1:0]  sel_pc;
  logic [31:0] jr_addr;
  logic        err_misalign;

  int vectors    = 0;
  int miscompares = 0;

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  logic        noise = 1'b0;
  logic        noise_t = 1'b0;

  logic [31:0] exp_addr = RESET_PC;
  logic        exp_err = 1'b0;
  int          cyc = 0;
  int          req_count = 0;
  int          last_req_cyc = 0;
  int          req_gap = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .inst_ready  (inst_ready),
    .sel_pc      (sel_pc),
    .jr_addr     (jr_addr),
    .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h0800_0004;
      32'h0000_0010: return 32'h1000_FFFE;
      32'h0000_000C: return 32'h03E0_0008;
      32'h3000_0000: return 32'h0800_0040;
      32'h3000_0100: return 32'h0320_0008;
      32'h0000_0100: return 32'h2129_0001;
      32'h0000_0104: return 32'h0300_0008;
      32'hFFFF_FFFC: return 32'h3C01_1234;
      default:       return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic [1:0] s, input logic [31:0] j);
    int off;
    case (s)
      2'd0: return p + 32'd4;
      2'd1: return ((p + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      2'd2: begin
        off = int'(w & 32'h0000_FFFF);
        if (off >= 32768) off = off - 65536;
        return p + 32'd4 + 32'(off * 4);
      end
      default: return j & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: answers each request after mem_lat cycles (0 = same cycle).
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (noise) begin
        imem_rvalid = ~noise_t;
        noise_t     = ~noise_t;
        imem_rdata  = $urandom;
      end else begin
        if (mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
          end
        end
        if (imem_req) begin
          if (mem_lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(imem_addr);
          end else begin
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
          end
        end
      end
    end
  end

  // Every-cycle compare against the architectural model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!nrst) begin
        exp_addr = RESET_PC;
        exp_err  = 1'b0;
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", inst_valid, 1'b0);
        chk1("rst_err", err_misalign, 1'b0);
        chk32("rst_pc", pc, RESET_PC);
        chk32("rst_inst", inst, 32'h0);
      end else begin
        if (imem_req) begin
          req_count++;
          req_gap      = cyc - last_req_cyc;
          last_req_cyc = cyc;
        end
        chk32("pc", pc, exp_addr);
        chk32("imem_addr", imem_addr, exp_addr);
        chk32("pc_plus4", pc_plus4, exp_addr + 32'd4);
        chk1("err_misalign", err_misalign, exp_err);
        if (inst_valid) begin
          chk1("req_while_valid", imem_req, 1'b0);
          chk32("inst", inst, mem_word(exp_addr));
          if (inst_ready) begin
            if (sel_pc == 2'd3 && jr_addr[1:0] != 2'b00) exp_err = 1'b1;
            exp_addr = model_next(exp_addr, mem_word(exp_addr), sel_pc, jr_addr);
          end
        end
      end
    end
  end

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: inst_valid timeout, got 0 expected 1", name);
    end
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: imem_req timeout, got 0 expected 1", name);
    end else begin
      chk32(name, imem_addr, exp);
    end
  endtask

  task automatic run_instr(input logic [1:0] sel, input logic [31:0] jr, input int lat_next,
                           input logic [31:0] exp_next, input string name);
    sel_pc     = sel;
    jr_addr    = jr;
    inst_ready = 1'b1;
    wait_valid(name);
    @(posedge clk);
    #1;
    mem_lat = lat_next;
    wait_req(name, exp_next);
  endtask

  initial begin
    int rc;
    nrst       = 1'b1;
    inst_ready = 1'b0;
    sel_pc     = 2'd0;
    jr_addr    = 32'h0;
    #1 nrst = 1'b0;
    #1;
    chk32("async_rst_pc", pc, RESET_PC);
    chk1("async_rst_req", imem_req, 1'b0);
    chk1("async_rst_valid", inst_valid, 1'b0);
    chk32("async_rst_addr", imem_addr, RESET_PC);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    inst_ready = 1'b1;

    wait_req("first_req_addr", 32'h0000_0000);
    wait_valid("first_valid");
    chk32("first_inst", inst, 32'h2008_0005);
    chk32("first_pc", pc, 32'h0000_0000);
    chk32("first_pc_plus4", pc_plus4, 32'h0000_0004);
    @(posedge clk);
    #1;
    wait_req("seq_next", 32'h0000_0004);
    chk_int("req_gap_lat1", req_gap, 3);

    run_instr(2'd1, 32'h0, 0, 32'h0000_0010, "jump_to_10");
    run_instr(2'd2, 32'h0, 1, 32'h0000_000C, "beq_back");
    chk_int("req_gap_lat0", req_gap, 2);
    run_instr(2'd3, 32'h3000_0000, 1, 32'h3000_0000, "jr_aligned");
    chk1("err_after_aligned_jr", err_misalign, 1'b0);
    run_instr(2'd1, 32'h0, 1, 32'h3000_0100, "jump_region");
    run_instr(2'd3, 32'h0000_0102, 1, 32'h0000_0100, "jr_misaligned");
    chk1("err_set", err_misalign, 1'b1);

    // Stall in the hold state with memory noise on the response lines.
    inst_ready = 1'b0;
    sel_pc     = 2'd0;
    wait_valid("hold_valid");
    rc = req_count;
    @(posedge clk);
    #1 noise = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("hold_valid_stays", inst_valid, 1'b1);
      chk32("hold_inst", inst, 32'h2129_0001);
      chk32("hold_pc", pc, 32'h0000_0100);
    end
    @(posedge clk);
    #1 noise = 1'b0;
    chk_int("hold_no_req", req_count, rc);
    inst_ready = 1'b1;
    wait_req("hold_release", 32'h0000_0104);
    chk_int("hold_single_req", req_count, rc + 1);
    @(negedge clk);
    chk1("hold_req_one_cycle", imem_req, 1'b0);

    run_instr(2'd3, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFC, "jr_top");
    run_instr(2'd0, 32'h0, 1, 32'h0000_0000, "wrap_to_zero");
    chk1("err_sticky", err_misalign, 1'b1);

    // Reset while a slow read is outstanding; its response lands during reset.
    run_instr(2'd0, 32'h0, 4, 32'h0000_0004, "slow_req");
    @(negedge clk);
    @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    chk32("midrst_pc", pc, RESET_PC);
    chk1("midrst_req", imem_req, 1'b0);
    chk1("midrst_err", err_misalign, 1'b0);
    chk32("midrst_inst", inst, 32'h0);
    repeat (8) @(posedge clk);
    mem_lat = 1;
    #1 nrst = 1'b1;
    wait_req("post_rst_req", RESET_PC);
    wait_valid("post_rst_valid");
    chk32("post_rst_inst", inst, 32'h2008_0005);
    chk1("post_rst_err", err_misalign, 1'b0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
